hazard_scoreboard_ctrl: RTL and testbench

- Parametrised scoreboard-based hazard and pipeline-flow controller for the 5-stage RV32 core; successor to the fixed load-use/branch hazard logic.
- Tracks in-flight long-latency producers (loads, multicycle M-unit ops) per architectural register.
- Generates stage enables/clears for RAW, WAW, structural (M-unit busy) and redirect hazards, and cancels squashed long ops.
- Sits beside the forwarding unit; single-cycle ALU producers remain covered by forwarding and are not scoreboarded.

---
 rtl/hazard_scoreboard_ctrl_if.sv | 57 +++++
 rtl/hazard_scoreboard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_scoreboard_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_ctrl_if.sv
// Pipeline-side bundle for the hazard/scoreboard controller: ID-stage decode info,
// writeback/M-unit events, and the stage enable/clear controls driven back.
interface hazard_scoreboard_ctrl_if #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_AW   = 5
);
  // ID stage
  logic                issue_valid_id;
  logic [REG_AW-1:0]   rs1_id;
  logic [REG_AW-1:0]   rs2_id;
  logic                use_rs1_id;
  logic                use_rs2_id;
  logic [REG_AW-1:0]   rd_id;
  logic                reg_write_id;
  logic                load_id;
  logic                mc_op_id;
  // Completion / control events
  logic                mc_done;
  logic                wb_valid;
  logic [REG_AW-1:0]   wb_rd;
  logic                redirect_mem;
  logic                stall_pipl;
  // Stage controls
  logic                pc_reg_en;
  logic                if_id_reg_en;
  logic                id_exe_reg_en;
  logic                exe_mem_reg_en;
  logic                mem_wb_reg_en;
  logic                if_id_reg_clr;
  logic                id_exe_reg_clr;
  logic                exe_mem_reg_clr;
  logic                mem_wb_reg_clr;
  // M-unit and status
  logic                mc_start;
  logic                mc_kill;
  logic                mc_busy;
  logic                hazard_stall;
  logic [NUM_REGS-1:0] pending;

  // Pipeline side
  modport master (
    output issue_valid_id, rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_id, reg_write_id,
           load_id, mc_op_id, mc_done, wb_valid, wb_rd, redirect_mem, stall_pipl,
    input  pc_reg_en, if_id_reg_en, id_exe_reg_en, exe_mem_reg_en, mem_wb_reg_en,
           if_id_reg_clr, id_exe_reg_clr, exe_mem_reg_clr, mem_wb_reg_clr,
           mc_start, mc_kill, mc_busy, hazard_stall, pending
  );

  // Controller side
  modport slave (
    input  issue_valid_id, rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_id, reg_write_id,
           load_id, mc_op_id, mc_done, wb_valid, wb_rd, redirect_mem, stall_pipl,
    output pc_reg_en, if_id_reg_en, id_exe_reg_en, exe_mem_reg_en, mem_wb_reg_en,
           if_id_reg_clr, id_exe_reg_clr, exe_mem_reg_clr, mem_wb_reg_clr,
           mc_start, mc_kill, mc_busy, hazard_stall, pending
  );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// Scoreboard-based hazard and pipeline-flow controller. Tracks registers owned by
// in-flight long producers (loads, M-unit ops), stalls ID on RAW/WAW/structural
// hazards, and squashes younger long ops on a MEM-stage redirect.
module hazard_scoreboard_ctrl #(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned SQUASH_DEPTH = 2
) (
  input logic                     clk,
  input logic                     reset_n,
  hazard_scoreboard_ctrl_if.slave ctrl_io
);

  typedef struct packed {
    logic              valid;
    logic              long_op;
    logic              mc;
    logic [REG_AW-1:0] rd;
  } hist_t;

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                mc_busy_q, mc_busy_d;
  hist_t               hist_q [SQUASH_DEPTH];
  hist_t               hist_d [SQUASH_DEPTH];

  logic clr_rs1, clr_rs2, clr_rd;
  logic raw, waw, struct_hz, hz;
  logic issue, long_wr, redirect_eff, mc_start, mc_kill;

  // Same-cycle writeback bypasses the scoreboard bit, so it never stalls
  assign clr_rs1 = ctrl_io.wb_valid && (ctrl_io.wb_rd == ctrl_io.rs1_id);
  assign clr_rs2 = ctrl_io.wb_valid && (ctrl_io.wb_rd == ctrl_io.rs2_id);
  assign clr_rd  = ctrl_io.wb_valid && (ctrl_io.wb_rd == ctrl_io.rd_id);

  assign long_wr   = ctrl_io.reg_write_id && (ctrl_io.load_id || ctrl_io.mc_op_id);
  assign raw       = (ctrl_io.use_rs1_id && pending_q[ctrl_io.rs1_id] && !clr_rs1) ||
                     (ctrl_io.use_rs2_id && pending_q[ctrl_io.rs2_id] && !clr_rs2);
  assign waw       = long_wr && pending_q[ctrl_io.rd_id] && !clr_rd;
  assign struct_hz = ctrl_io.mc_op_id && mc_busy_q && !ctrl_io.mc_done;
  assign hz        = ctrl_io.issue_valid_id && (raw || waw || struct_hz);

  // A redirect only acts once the pipeline is free to move
  assign redirect_eff = ctrl_io.redirect_mem && !ctrl_io.stall_pipl;
  assign mc_start     = issue && ctrl_io.mc_op_id;

  // Stage enables/clears by priority: freeze > redirect > hazard > normal
  always_comb begin
    ctrl_io.pc_reg_en       = 1'b1;
    ctrl_io.if_id_reg_en    = 1'b1;
    ctrl_io.id_exe_reg_en   = 1'b1;
    ctrl_io.exe_mem_reg_en  = 1'b1;
    ctrl_io.mem_wb_reg_en   = 1'b1;
    ctrl_io.if_id_reg_clr   = 1'b0;
    ctrl_io.id_exe_reg_clr  = 1'b0;
    ctrl_io.exe_mem_reg_clr = 1'b0;
    ctrl_io.mem_wb_reg_clr  = 1'b0;
    ctrl_io.hazard_stall    = 1'b0;
    issue                   = 1'b0;
    if (ctrl_io.stall_pipl) begin
      ctrl_io.pc_reg_en      = 1'b0;
      ctrl_io.if_id_reg_en   = 1'b0;
      ctrl_io.id_exe_reg_en  = 1'b0;
      ctrl_io.exe_mem_reg_en = 1'b0;
      ctrl_io.mem_wb_reg_en  = 1'b0;
    end else if (ctrl_io.redirect_mem) begin
      ctrl_io.if_id_reg_clr   = 1'b1;
      ctrl_io.id_exe_reg_clr  = 1'b1;
      ctrl_io.exe_mem_reg_clr = 1'b1;
    end else if (hz) begin
      ctrl_io.pc_reg_en      = 1'b0;
      ctrl_io.if_id_reg_en   = 1'b0;
      ctrl_io.id_exe_reg_clr = 1'b1;
      ctrl_io.hazard_stall   = 1'b1;
    end else begin
      issue = ctrl_io.issue_valid_id;
    end
  end

  // Kill any younger M-unit op still in the squash window
  always_comb begin
    mc_kill = 1'b0;
    for (int unsigned i = 0; i < SQUASH_DEPTH; i++) begin
      if (redirect_eff && hist_q[i].valid && hist_q[i].mc) mc_kill = 1'b1;
    end
  end

  // Scoreboard next state: clears first so a same-index set wins
  always_comb begin
    pending_d = pending_q;
    if (ctrl_io.wb_valid) pending_d[ctrl_io.wb_rd] = 1'b0;
    for (int unsigned i = 0; i < SQUASH_DEPTH; i++) begin
      // WAW stalls guarantee a squashed entry is the sole owner of its rd
      if (redirect_eff && hist_q[i].valid && hist_q[i].long_op) pending_d[hist_q[i].rd] = 1'b0;
    end
    if (issue && long_wr && (ctrl_io.rd_id != '0)) pending_d[ctrl_io.rd_id] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // M-unit occupancy: a start in the done cycle keeps it busy
  always_comb begin
    mc_busy_d = mc_busy_q;
    if (mc_start) begin
      mc_busy_d = 1'b1;
    end else if (ctrl_io.mc_done || mc_kill) begin
      mc_busy_d = 1'b0;
    end
  end

  // Squash history: entry 0 is the slot just issued, older slots shift behind it
  always_comb begin
    for (int unsigned i = 0; i < SQUASH_DEPTH; i++) hist_d[i] = hist_q[i];
    if (redirect_eff) begin
      for (int unsigned i = 0; i < SQUASH_DEPTH; i++) hist_d[i] = '0;
    end else if (!ctrl_io.stall_pipl) begin
      for (int unsigned i = 1; i < SQUASH_DEPTH; i++) hist_d[i] = hist_q[i-1];
      hist_d[0] = '0;
      if (issue) begin
        hist_d[0].valid   = 1'b1;
        hist_d[0].long_op = long_wr;
        hist_d[0].mc      = ctrl_io.mc_op_id;
        hist_d[0].rd      = ctrl_io.rd_id;
      end
    end
  end

  // State registers; reset aborts everything without a kill pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      mc_busy_q <= 1'b0;
      for (int unsigned i = 0; i < SQUASH_DEPTH; i++) hist_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      mc_busy_q <= mc_busy_d;
      for (int unsigned i = 0; i < SQUASH_DEPTH; i++) hist_q[i] <= hist_d[i];
    end
  end

  assign ctrl_io.mc_start = mc_start;
  assign ctrl_io.mc_kill  = mc_kill;
  assign ctrl_io.mc_busy  = mc_busy_q;
  assign ctrl_io.pending  = pending_q;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed table-driven bench for hazard_scoreboard_ctrl plus a reset sequence.
module tb_hazard_scoreboard_ctrl;

  localparam logic [4:0] EnAll  = 5'b11111;
  localparam logic [4:0] EnHz   = 5'b00111;
  localparam logic [4:0] EnNone = 5'b00000;
  localparam logic [3:0] ClNone = 4'b0000;
  localparam logic [3:0] ClHz   = 4'b0100;
  localparam logic [3:0] ClRd   = 4'b1110;

  typedef struct {
    bit       iv;
    bit [4:0] rs1;
    bit       u1;
    bit [4:0] rs2;
    bit       u2;
    bit [4:0] rd;
    bit       rw, ld, mc, mcd, wbv;
    bit [4:0] wbrd;
    bit       redir, stall;
    bit [4:0] en;
    bit [3:0] clr;
    bit       start, kill, busy, hs;
    bit [31:0] pend;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;
  vec_t vecs[$];

  hazard_scoreboard_ctrl_if #(.NUM_REGS(32), .REG_AW(5)) bus ();

  hazard_scoreboard_ctrl #(.NUM_REGS(32), .REG_AW(5), .SQUASH_DEPTH(2)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .ctrl_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic row(input bit iv, input bit [4:0] rs1, input bit u1, input bit [4:0] rs2,
                     input bit u2, input bit [4:0] rd, input bit rw, input bit ld,
                     input bit mc, input bit mcd, input bit wbv, input bit [4:0] wbrd,
                     input bit redir, input bit stall, input bit [4:0] en,
                     input bit [3:0] clr, input bit start, input bit kill, input bit busy,
                     input bit hs, input bit [31:0] pend);
    vec_t v;
    v.iv = iv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd;
    v.rw = rw; v.ld = ld; v.mc = mc; v.mcd = mcd; v.wbv = wbv; v.wbrd = wbrd;
    v.redir = redir; v.stall = stall; v.en = en; v.clr = clr; v.start = start;
    v.kill = kill; v.busy = busy; v.hs = hs; v.pend = pend;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    bus.issue_valid_id = v.iv;
    bus.rs1_id         = v.rs1;
    bus.use_rs1_id     = v.u1;
    bus.rs2_id         = v.rs2;
    bus.use_rs2_id     = v.u2;
    bus.rd_id          = v.rd;
    bus.reg_write_id   = v.rw;
    bus.load_id        = v.ld;
    bus.mc_op_id       = v.mc;
    bus.mc_done        = v.mcd;
    bus.wb_valid       = v.wbv;
    bus.wb_rd          = v.wbrd;
    bus.redirect_mem   = v.redir;
    bus.stall_pipl     = v.stall;
  endtask

  task automatic idle();
    vec_t v;
    v = '{default: 0};
    apply(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] en_vec();
    return {bus.pc_reg_en, bus.if_id_reg_en, bus.id_exe_reg_en, bus.exe_mem_reg_en,
            bus.mem_wb_reg_en};
  endfunction

  function automatic logic [3:0] clr_vec();
    return {bus.if_id_reg_clr, bus.id_exe_reg_clr, bus.exe_mem_reg_clr, bus.mem_wb_reg_clr};
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //   iv rs1 u1 rs2 u2 rd rw ld mc mcd wbv wbrd rdr stl  en     clr   st kl by hs pend
    // Load-use on x5, resolved by same-cycle writeback bypass
    row(1, 0, 0, 0, 0,  5, 1, 1, 0, 0, 0, 0,  0, 0, EnAll, ClNone, 0, 0, 0, 0, 32'h0);
    row(1, 5, 1, 1, 1,  6, 1, 0, 0, 0, 0, 0,  0, 0, EnHz,  ClHz,   0, 0, 0, 1, 32'h20);
    row(1, 5, 1, 1, 1,  6, 1, 0, 0, 0, 0, 0,  0, 0, EnHz,  ClHz,   0, 0, 0, 1, 32'h20);
    row(1, 5, 1, 1, 1,  6, 1, 0, 0, 0, 1, 5,  0, 0, EnAll, ClNone, 0, 0, 0, 0, 32'h20);
    row(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, EnAll, ClNone, 0, 0, 0, 0, 32'h0);
    // M-unit structural: div x7 then div x11 waits for mc_done
    row(1, 0, 0, 0, 0,  7, 1, 0, 1, 0, 0, 0,  0, 0, EnAll, ClNone, 1, 0, 0, 0, 32'h0);
    row(1, 0, 0, 0, 0, 11, 1, 0, 1, 0, 0, 0,  0, 0, EnHz,  ClHz,   0, 0, 1, 1, 32'h80);
    row(1, 0, 0, 0, 0, 11, 1, 0, 1, 0, 0, 0,  0, 0, EnHz,  ClHz,   0, 0, 1, 1, 32'h80);
    row(1, 0, 0, 0, 0, 11, 1, 0, 1, 1, 0, 0,  0, 0, EnAll, ClNone, 1, 0, 1, 0, 32'h80);
    row(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, EnAll, ClNone, 0, 0, 1, 0, 32'h880);
    row(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 7,  0, 0, EnAll, ClNone, 0, 0, 1, 0, 32'h880);
    row(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 11, 0, 0, EnAll, ClNone, 0, 0, 1, 0, 32'h800);
    row(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, EnAll, ClNone, 0, 0, 0, 0, 32'h0);
    // WAW on x8 with an independent add issuing in between
    row(1, 0, 0, 0, 0,  8, 1, 0, 1, 0, 0, 0,  0, 0, EnAll, ClNone, 1, 0, 0, 0, 32'h0);
    row(1, 1, 1, 2, 1,  9, 1, 0, 0, 0, 0, 0,  0, 0, EnAll, ClNone, 0, 0, 1, 0, 32'h100);
    row(1, 0, 0, 0, 0,  8, 1, 1, 0, 0, 0, 0,  0, 0, EnHz,  ClHz,   0, 0, 1, 1, 32'h100);
    row(1, 0, 0, 0, 0,  8, 1, 1, 0, 1, 0, 0,  0, 0, EnHz,  ClHz,   0, 0, 1, 1, 32'h100);
    row(1, 0, 0, 0, 0,  8, 1, 1, 0, 0, 1, 8,  0, 0, EnAll, ClNone, 0, 0, 0, 0, 32'h100);
    // Set and clear of x8 in the same cycle: set wins
    row(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, EnAll, ClNone, 0, 0, 0, 0, 32'h100);
    row(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 8,  0, 0, EnAll, ClNone, 0, 0, 0, 0, 32'h100);
    row(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, EnAll, ClNone, 0, 0, 0, 0, 32'h0);
    // Redirect squashes div x10
    row(1, 0, 0, 0, 0, 10, 1, 0, 1, 0, 0, 0,  0, 0, EnAll, ClNone, 1, 0, 0, 0, 32'h0);
    row(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0,  1, 0, EnAll, ClRd,   0, 1, 1, 0, 32'h400);
    row(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, EnAll, ClNone, 0, 0, 0, 0, 32'h0);
    // Freeze beats redirect and RAW; writeback still clears x5
    row(1, 0, 0, 0, 0,  5, 1, 1, 0, 0, 0, 0,  0, 0, EnAll, ClNone, 0, 0, 0, 0, 32'h0);
    row(1, 5, 1, 0, 0,  6, 1, 0, 0, 0, 1, 5,  1, 1, EnNone, ClNone, 0, 0, 0, 0, 32'h20);
    row(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, EnAll, ClNone, 0, 0, 0, 0, 32'h0);

    // Reset state
    reset_n = 1'b0;
    idle();
    #2;
    check("reset pending", bus.pending, 32'h0);
    check("reset mc_busy", {31'b0, bus.mc_busy}, 32'h0);
    check("reset enables", {27'b0, en_vec()}, {27'b0, EnAll});
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #2;
      check($sformatf("v%0d en", i), {27'b0, en_vec()}, {27'b0, vecs[i].en});
      check($sformatf("v%0d clr", i), {28'b0, clr_vec()}, {28'b0, vecs[i].clr});
      check($sformatf("v%0d mc_start", i), {31'b0, bus.mc_start}, {31'b0, vecs[i].start});
      check($sformatf("v%0d mc_kill", i), {31'b0, bus.mc_kill}, {31'b0, vecs[i].kill});
      check($sformatf("v%0d mc_busy", i), {31'b0, bus.mc_busy}, {31'b0, vecs[i].busy});
      check($sformatf("v%0d hazard_stall", i), {31'b0, bus.hazard_stall},
            {31'b0, vecs[i].hs});
      check($sformatf("v%0d pending", i), bus.pending, vecs[i].pend);
    end

    // Mid-operation asynchronous reset with x10 and x5 pending and the M-unit busy
    @(negedge clk);
    idle();
    bus.issue_valid_id = 1'b1; bus.rd_id = 5'd10; bus.reg_write_id = 1'b1; bus.mc_op_id = 1'b1;
    @(negedge clk);
    idle();
    bus.issue_valid_id = 1'b1; bus.rd_id = 5'd5; bus.reg_write_id = 1'b1; bus.load_id = 1'b1;
    @(negedge clk);
    idle();
    #2;
    check("pre-reset pending", bus.pending, 32'h420);
    check("pre-reset mc_busy", {31'b0, bus.mc_busy}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("async reset pending", bus.pending, 32'h0);
    check("async reset mc_busy", {31'b0, bus.mc_busy}, 32'h0);
    check("async reset mc_kill", {31'b0, bus.mc_kill}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    // Load to x0 never marks pending
    bus.issue_valid_id = 1'b1; bus.rd_id = 5'd0; bus.reg_write_id = 1'b1; bus.load_id = 1'b1;
    #2;
    check("x0 load enables", {27'b0, en_vec()}, {27'b0, EnAll});
    @(negedge clk);
    idle();
    #2;
    check("x0 load pending", bus.pending, 32'h0);
    check("post-reset mc_kill", {31'b0, bus.mc_kill}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
